// File: rtl/multiplicador_if.sv
// Operand/result bundle of the shift-and-add multiplier.
// The master side (requester) drives init and the two operands and observes
// the registered product and its completion pulse; the slave side is the
// multiplier itself.
interface multiplicador_if;
  logic       init;
  logic [2:0] MR;
  logic [2:0] MD;
  logic [5:0] pp;
  logic       done;

  modport master (
    output init,
    output MR,
    output MD,
    input  pp,
    input  done
  );

  modport slave (
    input  init,
    input  MR,
    input  MD,
    output pp,
    output done
  );
endinterface

// File: rtl/multiplicador.sv
// 3x3-bit unsigned shift-and-add multiplier.
// One operation takes a fixed five cycles from the init sample to the done
// pulse: LOAD (1 cycle), SHIFT_ADD (always 3 iterations, no early exit so the
// latency never depends on the operands) and DONE (1 cycle). Operands are
// captured only in LOAD, so they may change freely while an operation runs.
// The product register keeps the last result until the next LOAD clears it.
module multiplicador (
  input  logic                  clk,
  input  logic                  rst,
  multiplicador_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SHIFT_ADD = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Index of the last SHIFT_ADD iteration (iterations are counted 0..2).
  localparam logic [1:0] LAST_ITER = 2'd2;

  state_t     state_q, state_d;
  logic [5:0] a_q, a_d;      // shifted multiplicand
  logic [2:0] b_q, b_d;      // shifted multiplier, LSB selects the add
  logic [1:0] cnt_q, cnt_d;  // iteration counter
  logic [5:0] pp_q, pp_d;    // partial / final product
  logic       done_q, done_d;

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 6'd0;
      b_q     <= 3'd0;
      cnt_q   <= 2'd0;
      pp_q    <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      pp_q    <= pp_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: init is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.init) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = SHIFT_ADD;
      end
      SHIFT_ADD: begin
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT_ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output next values; done is raised on the edge that enters DONE.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    pp_d   = pp_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
      end
      LOAD: begin
        a_d   = {3'b000, bus.MD};
        b_d   = bus.MR;
        pp_d  = 6'd0;
        cnt_d = 2'd0;
      end
      SHIFT_ADD: begin
        if (b_q[0]) begin
          pp_d = pp_q + a_q;
        end else begin
          pp_d = pp_q;
        end
        a_d   = {a_q[4:0], 1'b0};
        b_d   = {1'b0, b_q[2:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LAST_ITER) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      DONE: begin
        done_d = 1'b0;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign bus.pp   = pp_q;
  assign bus.done = done_q;

  multiplicador_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .done (done_q),
    .pp   (pp_q)
  );

endmodule

// Property checker for the multiplier outputs.
module multiplicador_chk (
  input logic       clk,
  input logic       rst,
  input logic       done,
  input logic [5:0] pp
);

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

  // A 3x3 unsigned product never exceeds 49, including every partial sum.
  a_pp_range: assert property (@(posedge clk) pp <= 6'd49);

endmodule

// File: tb/tb_multiplicador.sv
// Scoreboard bench for multiplicador: stimulus pushes expected product and
// the cycle its done pulse is due; a monitor pops and checks on every done.
module tb_multiplicador;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [5:0] pp;
    int         due;
  } exp_t;

  exp_t exp_q[$];

  multiplicador_if bus ();

  multiplicador dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        e = exp_q.pop_front();
        check("product", int'(bus.pp), int'(e.pp));
        check("latency", cyc, e.due);
      end
    end
  end

  // Pulse init for one cycle with the given operands; optionally expect a result.
  task automatic start(input logic [2:0] md, input logic [2:0] mr, input bit expect_it);
    exp_t e;
    @(negedge clk);
    bus.MD   = md;
    bus.MR   = mr;
    bus.init = 1'b1;
    if (expect_it) begin
      e.pp  = 6'(int'(md) * int'(mr));
      e.due = cyc + 5;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.init = 1'b0;
  endtask

  // Wait (bounded) until every expected done has been seen.
  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d done pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    int   base;
    rst      = 1'b1;
    bus.init = 1'b0;
    bus.MD   = 3'd0;
    bus.MR   = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_pp", int'(bus.pp), 0);
    check("reset_done", int'(bus.done), 0);
    rst = 1'b0;

    // Zero operands.
    start(3'd0, 3'd0, 1'b1);
    wait_empty();

    // 5*3 and stability afterwards.
    start(3'd5, 3'd3, 1'b1);
    wait_empty();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pp_hold_15", int'(bus.pp), 15);
    end

    // Full operand sweep.
    for (int md = 0; md < 8; md++) begin
      for (int mr = 0; mr < 8; mr++) begin
        start(3'(md), 3'(mr), 1'b1);
        wait_empty();
      end
    end

    // 7*7 with operand changes and init pulses during SHIFT_ADD.
    start(3'd7, 3'd7, 1'b1);
    @(negedge clk);
    bus.MD   = 3'd1;
    bus.MR   = 3'd2;
    bus.init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.init = 1'b0;
    wait_empty();
    repeat (8) @(negedge clk);
    check("pp_hold_49", int'(bus.pp), 49);

    // Reset during SHIFT_ADD aborts the operation.
    start(3'd6, 3'd5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_pp", int'(bus.pp), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (8) @(negedge clk);
    start(3'd2, 3'd3, 1'b1);
    wait_empty();
    check("after_abort_pp", int'(bus.pp), 6);

    // init held high: back-to-back operations every 6 cycles.
    @(negedge clk);
    bus.MD   = 3'd3;
    bus.MR   = 3'd3;
    bus.init = 1'b1;
    base     = cyc;
    for (int i = 0; i < 4; i++) begin
      e.pp  = 6'd9;
      e.due = base + 5 + 6 * i;
      exp_q.push_back(e);
    end
    repeat (20) @(negedge clk);
    bus.init = 1'b0;
    wait_empty();
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multiplicador.md
MULTIPLICADOR -- requirements
Module: multiplicador

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-003 init  input  1  start request, level-sampled on rising edge.
REQ-004 MR  input  3  multiplier operand, unsigned.
REQ-005 MD  input  3  multiplicand operand, unsigned.
REQ-006 pp  output  6  registered product MD*MR, unsigned.
REQ-007 done  output  1  registered completion pulse.

Function
REQ-008 The block SHALL compute pp = MD*MR by shift-and-add, unsigned; max result 7*7=49 fits 6 bits, no overflow possible.
REQ-009 The FSM SHALL have states IDLE, LOAD, SHIFT_ADD, DONE.
REQ-010 IDLE: done=0, pp holds last result; init=1 at a clk edge -> LOAD, init=0 -> stay IDLE.
REQ-011 LOAD (1 cycle): A(6b) <= {3'b0,MD}, B(3b) <= MR, pp <= 0, iteration counter <= 0; -> SHIFT_ADD.
REQ-012 SHIFT_ADD (exactly 3 cycles): if B[0]=1 then pp <= pp + A; A <= A<<1; B <= B>>1; counter++; after 3rd iteration -> DONE.
REQ-013 Iteration count SHALL be fixed at 3 regardless of operand value (no early exit on B=0); latency is deterministic.
REQ-014 DONE (1 cycle): done=1, pp holds final product; -> IDLE unconditionally.
REQ-015 Latency: init sampled at edge N -> done=1 and valid pp during cycle following edge N+4; total 5 cycles init-to-done.
REQ-016 MR/MD SHALL be sampled only in LOAD; changes at any other time have no effect on the current operation.
REQ-017 init asserted in LOAD, SHIFT_ADD or DONE SHALL be ignored; no restart until FSM is back in IDLE.
REQ-018 init held continuously high SHALL cause back-to-back operations: DONE -> IDLE -> LOAD (one IDLE cycle between operations).
REQ-019 pp SHALL remain stable after DONE until the next LOAD clears it.
REQ-020 done SHALL be a single-cycle pulse per completed operation.

Reset
REQ-021 rst=1 at a clk edge SHALL force state=IDLE, pp=0, done=0, A=0, B=0, counter=0.
REQ-022 rst SHALL take priority over init and over any in-progress operation; an aborted operation produces no done pulse.
REQ-023 After rst deasserts, the block SHALL accept init on the next edge as from IDLE.

Verification
REQ-024 Bench: rst, then MD=0,MR=0, init pulse one cycle -> done pulse 5 cycles later, pp=0.
REQ-025 Bench: MD=5,MR=3 init pulse -> pp=15 with done=1 exactly 5 cycles after init sampled; pp stays 15 afterward.
REQ-026 Bench: full sweep MD,MR in 0..7, one init pulse each, wait for done -> pp=MD*MR for all 64 pairs (e.g. 7*7=49, 6*6=36, 4*2=8).
REQ-027 Bench: MD=7,MR=7 started; change MD/MR and pulse init during SHIFT_ADD -> result still 49, one done pulse only.
REQ-028 Bench: start MD=6,MR=5, assert rst during SHIFT_ADD -> pp=0, done=0 next cycle, no done pulse; then MD=2,MR=3 init -> pp=6.
REQ-029 Bench: hold init=1 continuously with MD=3,MR=3 -> done pulses every 6 cycles, pp=9 each time.
